uart_fifo_tx: RTL and testbench

- Transmit-side partner of the receive FIFO path. Drains bytes from a FIFO read port (pop strobe, registered data, empty flag) and serializes each byte as an 8N1 UART frame on `tx`.
- Sits between the FIFO read port and the UART/IrDA line driver.
- Back-to-back frames are sent automatically while the FIFO is non-empty.

---
 rtl/uart_fifo_tx.sv | 107 ++++++++++
 tb/tb_uart_fifo_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - FIFO-fed 8N1 UART transmitter; define UART_TX_IRDA_EN for IrDA SIR line coding
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int RD_LATENCY   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [1:0]        FETCH_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t                state, state_next;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [1:0]            fetch_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  baud_last;
  logic                  line_bit;

  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // line_bit is the logical bit on the wire; the line coder below maps it to tx
  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    busy       = 1'b1;
    tx_done    = 1'b0;
    line_bit   = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!fifo_empty && !reset) begin
          fifo_rd    = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (fetch_cnt == FETCH_LAST) state_next = START;
      end
      START: begin
        line_bit = 1'b0;
        if (baud_last) state_next = DATA;
      end
      DATA: begin
        line_bit = shreg[0];
        if (baud_last && bit_cnt == BIT_LAST) state_next = STOP;
      end
      STOP: begin
        if (baud_last) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      fetch_cnt <= '0;
      shreg     <= '0;
    end else begin
      if (state == START || state == DATA || state == STOP)
        baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
      else
        baud_cnt <= '0;

      if (state == FETCH) fetch_cnt <= fetch_cnt + 2'd1;
      else                fetch_cnt <= '0;

      if (state == FETCH && fetch_cnt == FETCH_LAST) shreg <= fifo_data;

      if (state == DATA && baud_last) begin
        shreg   <= shreg >> 1;
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

`ifdef UART_TX_IRDA_EN
  // SIR: a 3/16-bit high pulse at the start of each logical 0, line low otherwise
  localparam logic [BAUD_W-1:0] IRDA_PULSE = BAUD_W'((3 * CLKS_PER_BIT) / 16);
  assign tx = !line_bit && (baud_cnt < IRDA_PULSE);
`else
  assign tx = line_bit;
`endif

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - randomized bench for uart_fifo_tx against a frame-timing reference model
module tb_uart_fifo_tx;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int RL  = 1;
`ifdef UART_TX_IRDA_EN
  localparam logic IDLE_LVL = 1'b0;
`else
  localparam logic IDLE_LVL = 1'b1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DB-1:0] fifo_data = '0;
  logic          fifo_rd, tx, busy, tx_done;

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .RD_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clock = ~clock;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            s_cyc = -100000;
  int            n_free = 0;
  int            data_due = -1;
  int            exp_pops = 0;
  int            act_pops = 0;
  logic [DB-1:0] cur = '0;
  logic [DB-1:0] data_next = '0;
  bit            force_empty = 1'b0;
  logic [DB-1:0] fifo_q[$];

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected line level from frame start time and byte: start, LSB-first data, stop
  function automatic logic exp_tx_at(input int c);
    int   idx;
    logic bitv;
    if (!(c >= s_cyc && c < n_free)) return IDLE_LVL;
    idx = (c - s_cyc) / CPB;
    if (idx == 0)     bitv = 1'b0;
    else if (idx > DB) bitv = 1'b1;
    else              bitv = cur[idx-1];
`ifdef UART_TX_IRDA_EN
    return !bitv && (((c - s_cyc) % CPB) < (3 * CPB) / 16);
`else
    return bitv;
`endif
  endfunction

  task automatic step(input bit rst_in);
    logic exp_rd, in_frame;
    @(negedge clock);
    reset      = rst_in;
    fifo_empty = force_empty || (fifo_q.size() == 0);
    fifo_data  = (cyc == data_due) ? data_next : DB'($urandom);
    #1;
    exp_rd   = !rst_in && (cyc >= n_free) && !fifo_empty;
    in_frame = (cyc >= s_cyc) && (cyc < n_free);
    chk_bit("fifo_rd", fifo_rd, exp_rd);
    chk_bit("tx", tx, exp_tx_at(cyc));
    chk_bit("busy", busy, cyc < n_free);
    chk_bit("tx_done", tx_done, in_frame && (cyc == n_free - 1));
    if (fifo_rd === 1'b1) act_pops++;
    if (exp_rd) begin
      cur       = fifo_q.pop_front();
      data_next = cur;
      data_due  = cyc + RL;
      s_cyc     = cyc + 1 + RL;
      n_free    = s_cyc + (DB + 2) * CPB;
      exp_pops++;
    end
    if (rst_in) begin
      n_free   = cyc + 1;
      data_due = -1;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    int n;
    // reset and idle with an empty FIFO
    for (int i = 0; i < 3; i++) step(1'b1);
    run(200);

    // single 0xA5 frame
    fifo_q.push_back(8'hA5);
    run(200);

    // back-to-back frames
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    run(3 * (DB + 2) * CPB + 40);

    // empty flag wiggling mid-frame must not cause a pop
    fifo_q.push_back(DB'($urandom));
    run(2 + 3 * CPB);
    for (int i = 0; i < 8; i++) begin
      force_empty = ~force_empty;
      run(4);
    end
    force_empty = 1'b0;
    run(150);

    // reset during data bit 4, then resume with the remaining byte
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'hC3);
    n = 0;
    while (!(cyc == s_cyc + 5 * CPB + 3 && cyc < n_free) && n < 2000) begin
      step(1'b0);
      n++;
    end
    chk_int("reach_bit4", n < 2000, 1);
    step(1'b1);
    run(200);

    // randomized traffic, empty-flag glitches and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0 && fifo_q.size() < 4) fifo_q.push_back(DB'($urandom));
      if ($urandom_range(0, 49) == 0) force_empty = ~force_empty;
      step($urandom_range(0, 699) == 0);
    end
    force_empty = 1'b0;
    n = 0;
    while ((fifo_q.size() != 0 || cyc < n_free + 5) && n < 3000) begin
      step(1'b0);
      n++;
    end
    chk_int("drain", n < 3000, 1);
    chk_int("pop_count", act_pops, exp_pops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
